lms_wb_sequencer: RTL and testbench

Wishbone master that sequences the wb_lms adaptive-filter slave without software involvement.
- On a command it loads gamma, clears the filter and streams sample pairs (x, d) from a local dual-bank sample memory into the slave's FIFO registers.
- In train mode it then enables training. In run mode it disables training, clears, and streams x only.
- It sits between a host command interface and the wb_lms Wishbone slave port.

---
 rtl/lms_seq_pkg.sv | 33 +++
 rtl/lms_wb_write_port.sv | 63 ++++++
 rtl/lms_wb_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_lms_wb_sequencer.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lms_seq_pkg.sv
// Shared types and constants for the wb_lms Wishbone sequencer.
package lms_seq_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StWrGamma,
    StWrClr,
    StWrDis,
    StRdMem,
    StWaitMem,
    StWrX,
    StWrD,
    StWrEn,
    StDone
  } state_e;

  // wb_lms register map
  localparam logic [31:0] LMS_CTRL_ADDR  = 32'h00;
  localparam logic [31:0] LMS_GAMMA_ADDR = 32'h08;
  localparam logic [31:0] LMS_X_ADDR     = 32'h0C;
  localparam logic [31:0] LMS_D_ADDR     = 32'h10;

  // Control register codes
  localparam logic [15:0] CTRL_CLEAR     = 16'h0008;
  localparam logic [15:0] CTRL_TRAIN_EN  = 16'h0005;
  localparam logic [15:0] CTRL_TRAIN_DIS = 16'h0004;

  // States that own a Wishbone write
  function automatic logic is_wr_state(state_e s);
    return s inside {StWrGamma, StWrClr, StWrDis, StWrX, StWrD, StWrEn};
  endfunction

endpackage

// File: rtl/lms_wb_write_port.sv
// Single Wishbone write: latches address/data on req, holds them while stb is high,
// and aborts the strobe after TIMEOUT cycles without ack.
module lms_wb_write_port #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic [15:0] data_i,
  input  logic        ack_i,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [31:0] adr_o,
  output logic [15:0] dat_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        timeout_o
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic          stb_q;
  logic [31:0]   adr_q;
  logic [15:0]   dat_q;
  logic [TW-1:0] wait_q;

  // Completion and abort are decided on the edge that samples ack
  always_comb begin
    done_o    = stb_q & ack_i;
    timeout_o = stb_q & ~ack_i & (wait_q == TW'(TIMEOUT - 1));
  end

  // Strobe, held address/data and the per-transfer wait counter
  always_ff @(posedge Clk) begin
    if (Rst) begin
      stb_q  <= 1'b0;
      adr_q  <= '0;
      dat_q  <= '0;
      wait_q <= '0;
    end else if (stb_q) begin
      if (done_o || timeout_o) begin
        stb_q <= 1'b0;
      end else begin
        wait_q <= wait_q + TW'(1);
      end
    end else if (req_i) begin
      stb_q  <= 1'b1;
      adr_q  <= addr_i;
      dat_q  <= data_i;
      wait_q <= '0;
    end
  end

  assign cyc_o  = stb_q;
  assign stb_o  = stb_q;
  assign we_o   = stb_q;
  assign adr_o  = adr_q;
  assign dat_o  = dat_q;
  assign busy_o = stb_q;

endmodule

// File: rtl/lms_wb_sequencer.sv
// Wishbone master that configures wb_lms and streams (x, d) sample pairs from a
// local sample memory into its FIFO registers, in train or run mode.
module lms_wb_sequencer
  import lms_seq_pkg::*;
#(
  parameter int unsigned SAMP_AW    = 8,
  parameter logic [31:0] CTRL_ADDR  = LMS_CTRL_ADDR,
  parameter logic [31:0] GAMMA_ADDR = LMS_GAMMA_ADDR,
  parameter logic [31:0] X_ADDR     = LMS_X_ADDR,
  parameter logic [31:0] D_ADDR     = LMS_D_ADDR,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic               cmd_train_i,
  input  logic [15:0]        cmd_gamma_i,
  input  logic [SAMP_AW:0]   cmd_len_i,
  output logic [SAMP_AW-1:0] mem_addr_o,
  output logic               mem_rd_o,
  input  logic [15:0]        mem_x_i,
  input  logic [15:0]        mem_d_i,
  output logic               wb_cyc_o,
  output logic               wb_stb_o,
  output logic               wb_we_o,
  output logic [31:0]        wb_adr_o,
  output logic [15:0]        wb_dat_o,
  input  logic               wb_ack_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic [SAMP_AW:0]   cnt_o
);

  state_e             state_q, state_d;
  logic               train_q, train_d;
  logic [15:0]        gamma_q, gamma_d;
  logic [SAMP_AW:0]   len_q, len_d;
  logic [SAMP_AW:0]   cnt_q, cnt_d, cnt_inc;
  logic [SAMP_AW-1:0] idx_q, idx_d;
  logic               err_q, err_d;
  logic [15:0]        x_q, x_d, d_q, d_d;

  logic        wr_req, wr_busy, wr_done, wr_timeout;
  logic [31:0] wr_addr;
  logic [15:0] wr_data;

  lms_wb_write_port #(
    .TIMEOUT (TIMEOUT)
  ) u_wr (
    .Clk       (Clk),
    .Rst       (Rst),
    .req_i     (wr_req),
    .addr_i    (wr_addr),
    .data_i    (wr_data),
    .ack_i     (wb_ack_i),
    .cyc_o     (wb_cyc_o),
    .stb_o     (wb_stb_o),
    .we_o      (wb_we_o),
    .adr_o     (wb_adr_o),
    .dat_o     (wb_dat_o),
    .busy_o    (wr_busy),
    .done_o    (wr_done),
    .timeout_o (wr_timeout)
  );

  // Next-state, write request and sample bookkeeping
  always_comb begin
    state_d  = state_q;
    train_d  = train_q;
    gamma_d  = gamma_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    err_d    = err_q;
    x_d      = x_q;
    d_d      = d_q;
    wr_addr  = CTRL_ADDR;
    wr_data  = 16'h0000;
    mem_rd_o = 1'b0;
    cnt_inc  = cnt_q + (SAMP_AW + 1)'(1);
    // A write state issues its request once, in any cycle the port is idle;
    // this also gives the mandatory idle cycle after the previous ack.
    wr_req   = is_wr_state(state_q) && !wr_busy;

    case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          train_d = cmd_train_i;
          gamma_d = cmd_gamma_i;
          len_d   = cmd_len_i;
          cnt_d   = '0;
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = cmd_train_i ? StWrGamma : StWrDis;
        end
      end
      StWrGamma: begin
        wr_addr = GAMMA_ADDR;
        wr_data = gamma_q;
        if (wr_done) state_d = StWrClr;
      end
      StWrDis: begin
        wr_data = CTRL_TRAIN_DIS;
        if (wr_done) state_d = StWrClr;
      end
      StWrClr: begin
        wr_data = CTRL_CLEAR;
        if (wr_done) begin
          if (len_q == '0) state_d = train_q ? StWrEn : StDone;
          else             state_d = StRdMem;
        end
      end
      StRdMem: begin
        mem_rd_o = 1'b1;
        state_d  = StWaitMem;
      end
      StWaitMem: begin
        x_d     = mem_x_i;
        d_d     = mem_d_i;
        state_d = StWrX;
      end
      StWrX: begin
        wr_addr = X_ADDR;
        wr_data = x_q;
        if (wr_done) begin
          if (train_q) begin
            state_d = StWrD;
          end else begin
            idx_d   = idx_q + SAMP_AW'(1);
            cnt_d   = cnt_inc;
            state_d = (cnt_inc == len_q) ? StDone : StRdMem;
          end
        end
      end
      StWrD: begin
        wr_addr = D_ADDR;
        wr_data = d_q;
        if (wr_done) begin
          idx_d   = idx_q + SAMP_AW'(1);
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == len_q) ? StWrEn : StRdMem;
        end
      end
      StWrEn: begin
        wr_data = CTRL_TRAIN_EN;
        if (wr_done) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // An unanswered strobe abandons the whole sequence
    if (wr_timeout) begin
      err_d   = 1'b1;
      state_d = StDone;
    end
  end

  // Sequencer state and captured command
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= StIdle;
      train_q <= 1'b0;
      gamma_q <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      x_q     <= '0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      train_q <= train_d;
      gamma_q <= gamma_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      x_q     <= x_d;
      d_q     <= d_d;
    end
  end

  assign cmd_ready_o = (state_q == StIdle);
  assign busy_o      = (state_q != StIdle) && (state_q != StDone);
  assign done_o      = (state_q == StDone);
  assign err_o       = err_q;
  assign cnt_o       = cnt_q;
  assign mem_addr_o  = idx_q;

endmodule

// File: tb/tb_lms_wb_sequencer.sv
// Bench for lms_wb_sequencer: scoreboard of expected Wishbone writes, behavioural
// sample memory and a slave with programmable ack latency.
module tb_lms_wb_sequencer;

  localparam int SAMP_AW = 8;

  logic               Clk = 1'b0;
  logic               Rst;
  logic               cmd_valid_i, cmd_ready_o, cmd_train_i;
  logic [15:0]        cmd_gamma_i;
  logic [SAMP_AW:0]   cmd_len_i;
  logic [SAMP_AW-1:0] mem_addr_o;
  logic               mem_rd_o;
  logic [15:0]        mem_x_i = '0;
  logic [15:0]        mem_d_i = '0;
  logic               wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
  logic [31:0]        wb_adr_o;
  logic [15:0]        wb_dat_o;
  logic               busy_o, done_o, err_o;
  logic [SAMP_AW:0]   cnt_o;

  always #5 Clk = ~Clk;

  lms_wb_sequencer #(
    .SAMP_AW (SAMP_AW),
    .TIMEOUT (255)
  ) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_train_i (cmd_train_i),
    .cmd_gamma_i (cmd_gamma_i),
    .cmd_len_i   (cmd_len_i),
    .mem_addr_o  (mem_addr_o),
    .mem_rd_o    (mem_rd_o),
    .mem_x_i     (mem_x_i),
    .mem_d_i     (mem_d_i),
    .wb_cyc_o    (wb_cyc_o),
    .wb_stb_o    (wb_stb_o),
    .wb_we_o     (wb_we_o),
    .wb_adr_o    (wb_adr_o),
    .wb_dat_o    (wb_dat_o),
    .wb_ack_i    (wb_ack_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .cnt_o       (cnt_o)
  );

  // Slave: ack after ack_delay wait cycles of strobe, or never when ack_en is low
  int unsigned ack_delay = 0;
  bit          ack_en    = 1'b1;
  int unsigned wait_cnt  = 0;
  always @(posedge Clk) begin
    if (wb_stb_o && !wb_ack_i) wait_cnt <= wait_cnt + 1;
    else                       wait_cnt <= 0;
  end
  assign wb_ack_i = wb_stb_o && ack_en && (wait_cnt == ack_delay);

  // Sample memory, one-cycle read latency
  logic [15:0] x_mem [256];
  logic [15:0] d_mem [256];
  always @(posedge Clk) begin
    if (mem_rd_o) begin
      mem_x_i <= x_mem[mem_addr_o];
      mem_d_i <= d_mem[mem_addr_o];
    end
  end

  int total = 0;
  int bad   = 0;

  logic [47:0] exp_q[$];
  logic [47:0] obs_q[$];

  // Observations from the last collect call
  int          done_cnt, rd_cnt, max_run, min_run, abort_run;
  int          hold_bad, gap_bad, addr_bad;
  bit          finished, busy_at_done, err_at_done;
  logic [31:0] abort_adr;
  logic [SAMP_AW:0] cnt_at_done;

  // Reference sequence of (adr, dat) writes for one command
  task automatic model_push(input bit train, input logic [15:0] g, input int len);
    if (train) begin
      exp_q.push_back({32'h08, g});
      exp_q.push_back({32'h00, 16'h0008});
      for (int i = 0; i < len; i++) begin
        exp_q.push_back({32'h0C, x_mem[i]});
        exp_q.push_back({32'h10, d_mem[i]});
      end
      exp_q.push_back({32'h00, 16'h0005});
    end else begin
      exp_q.push_back({32'h00, 16'h0004});
      exp_q.push_back({32'h00, 16'h0008});
      for (int i = 0; i < len; i++) exp_q.push_back({32'h0C, x_mem[i]});
    end
  endtask

  task automatic start_cmd(input bit train, input logic [15:0] g, input int len);
    @(negedge Clk);
    cmd_valid_i = 1'b1;
    cmd_train_i = train;
    cmd_gamma_i = g;
    cmd_len_i   = (SAMP_AW + 1)'(len);
    model_push(train, g, len);
    @(negedge Clk);
    cmd_valid_i = 1'b0;
  endtask

  // Monitor loop: records completed writes and protocol statistics until done_o,
  // until stop_obs writes are complete with a strobe pending, or the budget expires.
  task automatic collect(input int max_cycles, input int stop_obs, input int pulse_at);
    int          run;
    bit          prev_xfer, prev_stb;
    logic [31:0] h_adr;
    logic [15:0] h_dat;
    logic [7:0]  exp_addr;
    obs_q.delete();
    done_cnt = 0; rd_cnt = 0; max_run = 0; min_run = 1 << 30; abort_run = 0;
    hold_bad = 0; gap_bad = 0; addr_bad = 0; finished = 0; abort_adr = '0;
    run = 0; prev_xfer = 0; prev_stb = 0; h_adr = '0; h_dat = '0; exp_addr = '0;
    for (int c = 0; c < max_cycles; c++) begin
      if (c > 0) @(negedge Clk);
      if (c == pulse_at) begin
        cmd_valid_i = 1'b1;
        cmd_train_i = 1'b0;
        cmd_len_i   = 9'd5;
      end else if (c == pulse_at + 1) begin
        cmd_valid_i = 1'b0;
      end
      if (stop_obs >= 0 && obs_q.size() == stop_obs && wb_stb_o) return;
      if (mem_rd_o) begin
        if (mem_addr_o !== exp_addr) addr_bad++;
        exp_addr++;
        rd_cnt++;
      end
      if (wb_stb_o) begin
        if (prev_xfer) gap_bad++;
        if (!wb_cyc_o || !wb_we_o) hold_bad++;
        if (prev_stb && (wb_adr_o !== h_adr || wb_dat_o !== h_dat)) hold_bad++;
        h_adr = wb_adr_o;
        h_dat = wb_dat_o;
        run++;
        if (wb_ack_i) begin
          obs_q.push_back({wb_adr_o, wb_dat_o});
          if (run > max_run) max_run = run;
          if (run < min_run) min_run = run;
          run = 0;
        end
      end else if (run > 0) begin
        abort_run = run;
        abort_adr = h_adr;
        run = 0;
      end
      prev_xfer = wb_stb_o && wb_ack_i;
      prev_stb  = wb_stb_o && !wb_ack_i;
      if (done_o) begin
        done_cnt++;
        busy_at_done = busy_o;
        cnt_at_done  = cnt_o;
        err_at_done  = err_o;
        finished     = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    cmd_valid_i = 1'b0; cmd_train_i = 1'b0; cmd_gamma_i = '0; cmd_len_i = '0;
    repeat (3) @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    total++; if (cmd_ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", cmd_ready_o); end
    total++; if ({wb_cyc_o, wb_stb_o, wb_we_o, mem_rd_o} !== 4'b0000) begin
      bad++; $display("FAIL rst_wb got=%b want=0000", {wb_cyc_o, wb_stb_o, wb_we_o, mem_rd_o});
    end
    total++; if ({busy_o, done_o, err_o} !== 3'b000) begin
      bad++; $display("FAIL rst_status got=%b want=000", {busy_o, done_o, err_o});
    end
    total++; if (cnt_o !== '0 || wb_adr_o !== '0 || wb_dat_o !== '0 || mem_addr_o !== '0) begin
      bad++; $display("FAIL rst_values cnt=%h adr=%h dat=%h maddr=%h want all 0", cnt_o, wb_adr_o, wb_dat_o, mem_addr_o);
    end
  endtask

  task automatic test_train();
    int n;
    start_cmd(1'b1, 16'h0333, 4);
    collect(500, -1, -1);
    total++; if (!finished) begin bad++; $display("FAIL train_done got=0 want=1"); end
    total++; if (obs_q.size() != 11) begin bad++; $display("FAIL train_count got=%0d want=11", obs_q.size()); end
    n = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [47:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL train_xfer[%0d] got=%h want=%h", n, o, e); end
      n++;
    end
    exp_q.delete();
    total++; if (cnt_at_done !== 9'd4 || err_at_done !== 1'b0 || busy_at_done !== 1'b0) begin
      bad++; $display("FAIL train_status cnt=%0d err=%b busy=%b want 4,0,0", cnt_at_done, err_at_done, busy_at_done);
    end
    total++; if (max_run != 1 || gap_bad != 0 || rd_cnt != 4 || addr_bad != 0) begin
      bad++; $display("FAIL train_proto run=%0d gap=%0d rd=%0d addr=%0d want 1,0,4,0", max_run, gap_bad, rd_cnt, addr_bad);
    end
    @(negedge Clk);
    total++; if (cmd_ready_o !== 1'b1 || done_o !== 1'b0) begin
      bad++; $display("FAIL train_after ready=%b done=%b want 1,0", cmd_ready_o, done_o);
    end
  endtask

  task automatic test_run();
    int lens [2] = '{3, 0};
    for (int t = 0; t < 2; t++) begin
      int n;
      start_cmd(1'b0, 16'hBEEF, lens[t]);
      collect(500, -1, -1);
      total++; if (!finished) begin bad++; $display("FAIL run_done[len%0d] got=0 want=1", lens[t]); end
      total++; if (obs_q.size() != exp_q.size()) begin
        bad++; $display("FAIL run_count[len%0d] got=%0d want=%0d", lens[t], obs_q.size(), exp_q.size());
      end
      n = 0;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        logic [47:0] e, o;
        e = exp_q.pop_front(); o = obs_q.pop_front();
        total++; if (o !== e) begin bad++; $display("FAIL run_xfer[len%0d][%0d] got=%h want=%h", lens[t], n, o, e); end
        n++;
      end
      exp_q.delete();
      total++; if (cnt_at_done !== (SAMP_AW + 1)'(lens[t]) || rd_cnt != lens[t]) begin
        bad++; $display("FAIL run_cnt[len%0d] cnt=%0d rd=%0d want %0d", lens[t], cnt_at_done, rd_cnt, lens[t]);
      end
      @(negedge Clk);
    end
  endtask

  task automatic test_wait_states();
    int n;
    ack_delay = 3;
    start_cmd(1'b1, 16'h1234, 2);
    collect(500, -1, -1);
    total++; if (!finished) begin bad++; $display("FAIL wait_done got=0 want=1"); end
    total++; if (min_run != 4 || max_run != 4) begin
      bad++; $display("FAIL wait_stb_len min=%0d max=%0d want 4", min_run, max_run);
    end
    total++; if (hold_bad != 0 || gap_bad != 0) begin
      bad++; $display("FAIL wait_hold hold=%0d gap=%0d want 0,0", hold_bad, gap_bad);
    end
    total++; if (obs_q.size() != 7) begin bad++; $display("FAIL wait_count got=%0d want=7", obs_q.size()); end
    n = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [47:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL wait_xfer[%0d] got=%h want=%h", n, o, e); end
      n++;
    end
    exp_q.delete();
    ack_delay = 0;
    @(negedge Clk);
  endtask

  task automatic test_timeout();
    ack_en = 1'b0;
    start_cmd(1'b1, 16'h0777, 2);
    exp_q.delete();
    collect(600, -1, -1);
    total++; if (!finished || done_cnt != 1) begin
      bad++; $display("FAIL to_done finished=%b pulses=%0d want 1,1", finished, done_cnt);
    end
    total++; if (abort_run != 255 || abort_adr !== 32'h08) begin
      bad++; $display("FAIL to_stb cycles=%0d adr=%h want 255,08", abort_run, abort_adr);
    end
    total++; if (err_at_done !== 1'b1 || cnt_at_done !== '0 || obs_q.size() != 0) begin
      bad++; $display("FAIL to_status err=%b cnt=%0d xfers=%0d want 1,0,0", err_at_done, cnt_at_done, obs_q.size());
    end
    @(negedge Clk);
    total++; if (err_o !== 1'b1 || wb_stb_o !== 1'b0) begin
      bad++; $display("FAIL to_sticky err=%b stb=%b want 1,0", err_o, wb_stb_o);
    end
    ack_en = 1'b1;
    start_cmd(1'b0, 16'h0000, 1);
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL to_clear err=%b want 0", err_o); end
    collect(200, -1, -1);
    total++; if (!finished || obs_q.size() != 3 || err_at_done !== 1'b0) begin
      bad++; $display("FAIL to_recover done=%b xfers=%0d err=%b want 1,3,0", finished, obs_q.size(), err_at_done);
    end
    exp_q.delete();
    @(negedge Clk);
  endtask

  task automatic test_reset_mid();
    int n;
    start_cmd(1'b1, 16'h0042, 4);
    exp_q.delete();
    collect(300, 6, -1);
    total++; if (!(wb_stb_o && wb_adr_o === 32'h0C && wb_dat_o === x_mem[2])) begin
      bad++; $display("FAIL rm_point stb=%b adr=%h dat=%h want 1,0c,%h", wb_stb_o, wb_adr_o, wb_dat_o, x_mem[2]);
    end
    Rst = 1'b1;
    @(negedge Clk);
    total++; if ({wb_cyc_o, wb_stb_o, busy_o, done_o, cmd_ready_o} !== 5'b00001) begin
      bad++; $display("FAIL rm_reset got=%b want=00001", {wb_cyc_o, wb_stb_o, busy_o, done_o, cmd_ready_o});
    end
    Rst = 1'b0;
    start_cmd(1'b0, 16'h0000, 2);
    collect(200, -1, -1);
    total++; if (!finished || addr_bad != 0 || rd_cnt != 2 || obs_q.size() != 4) begin
      bad++; $display("FAIL rm_restart done=%b addr=%0d rd=%0d xfers=%0d want 1,0,2,4", finished, addr_bad, rd_cnt, obs_q.size());
    end
    n = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [47:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL rm_xfer[%0d] got=%h want=%h", n, o, e); end
      n++;
    end
    exp_q.delete();
    @(negedge Clk);
  endtask

  task automatic test_back_to_back();
    int n;
    start_cmd(1'b1, 16'h0101, 256);
    collect(4000, -1, 100);
    total++; if (!finished) begin bad++; $display("FAIL full_done got=0 want=1"); end
    total++; if (obs_q.size() != 515) begin bad++; $display("FAIL full_count got=%0d want=515", obs_q.size()); end
    total++; if (cnt_at_done !== 9'd256 || rd_cnt != 256 || addr_bad != 0) begin
      bad++; $display("FAIL full_mem cnt=%0d rd=%0d addr=%0d want 256,256,0", cnt_at_done, rd_cnt, addr_bad);
    end
    n = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [47:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL full_xfer[%0d] got=%h want=%h", n, o, e); end
      n++;
    end
    exp_q.delete();
    repeat (3) @(negedge Clk);
    total++; if (busy_o !== 1'b0 || cmd_ready_o !== 1'b1 || wb_stb_o !== 1'b0) begin
      bad++; $display("FAIL full_idle busy=%b ready=%b stb=%b want 0,1,0", busy_o, cmd_ready_o, wb_stb_o);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      x_mem[i] = 16'(16'hA000 + i);
      d_mem[i] = 16'(i * 37 + 5);
    end
    test_reset();
    test_train();
    test_run();
    test_wait_states();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
